// File: rtl/flash_pkg.sv
// Shared constants and types for the flash op sequencer.
// Macro codes, QSPI opcodes, FSM states, transaction request bundle.
package flash_pkg;

  localparam logic [3:0] M_ERS4K = 4'hA;
  localparam logic [3:0] M_RDID  = 4'hB;
  localparam logic [3:0] M_WRPG  = 4'hC;
  localparam logic [3:0] M_RDPG  = 4'hD;
  localparam logic [3:0] M_RDSR  = 4'hE;
  localparam logic [3:0] M_RDFR  = 4'hF;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_RDFR = 8'h70;
  localparam logic [7:0] OP_RDID = 8'h9F;

  localparam int PG_BYTES_DEF = 256;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WREN,
    S_WREN_WT,
    S_CMD,
    S_CMD_WT,
    S_GAP,
    S_RDSR,
    S_RDSR_WT,
    S_CHECK,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic        has_addr;
    logic [8:0]  len;
  } qspi_req_t;

  function automatic logic is_cmd(input logic [3:0] c);
    return c >= M_ERS4K;
  endfunction

  function automatic logic needs_wren(input logic [3:0] c);
    return (c == M_ERS4K) || (c == M_WRPG);
  endfunction

endpackage

// File: rtl/flash_poll_timer.sv
// Gap and poll counter for status-register polling.
// Ports: clk, rst, gap_load, poll_clr, poll_inc -> gap_expire, poll_timeout.
module flash_poll_timer #(
  parameter int POLL_GAP = 64,
  parameter int POLL_MAX = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic gap_load,
  input  logic poll_clr,
  input  logic poll_inc,
  output logic gap_expire,
  output logic poll_timeout
);

  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] poll_cnt;

  // Loaded with POLL_GAP-1 so the GAP state lasts POLL_GAP cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt  <= '0;
      poll_cnt <= '0;
    end else begin
      if (gap_load)
        gap_cnt <= GW'(POLL_GAP - 1);
      else if (gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
      if (poll_clr)
        poll_cnt <= '0;
      else if (poll_inc && !poll_timeout)
        poll_cnt <= poll_cnt + 1'b1;
    end
  end

  assign gap_expire = (gap_cnt == '0);

  // poll_cnt holds completed polls before the one being checked.
  assign poll_timeout = (poll_cnt >= PW'(POLL_MAX - 1));

endmodule

// File: rtl/flash_op_sequencer.sv
// Turns one flash macro command into ordered QSPI transactions:
// optional WREN, the command, then RDSR polling until WIP clears.
// In: clk, rst, macro_states, macro_states_valid, addr_reg,
//     qspi_done, qspi_rd_data, qspi_rd_valid.
// Out: flash_macro_states_done, flash_busy, flash_err, qspi_start,
//      qspi_cmd, qspi_addr, qspi_has_addr, qspi_len, status_reg, id_reg.
// Option: FLASH_SEQ_TIMEOUT_EN bounds polling to POLL_MAX and
//         reports the timeout on flash_err.
module flash_op_sequencer
  import flash_pkg::*;
#(
  parameter int POLL_GAP = 64,
  parameter int POLL_MAX = 200000,
  parameter int PG_BYTES = PG_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  macro_states,
  input  logic        macro_states_valid,
  input  logic [31:0] addr_reg,
  output logic        flash_macro_states_done,
  output logic        flash_busy,
  output logic        flash_err,
  output logic        qspi_start,
  output logic [7:0]  qspi_cmd,
  output logic [23:0] qspi_addr,
  output logic        qspi_has_addr,
  output logic [8:0]  qspi_len,
  input  logic        qspi_done,
  input  logic [7:0]  qspi_rd_data,
  input  logic        qspi_rd_valid,
  output logic [7:0]  status_reg,
  output logic [23:0] id_reg
);

  seq_state_t state, state_n;
  qspi_req_t  req_q, req_n, cmd_req;

  logic [3:0]  code_q, code_c;
  logic [23:0] addr_q, addr_c;
  logic        accept, wip, timed_out;
  logic        gap_load, poll_clr, poll_inc;
  logic        gap_expire, poll_timeout;
  logic        unused_hi;

  assign unused_hi = ^addr_reg[31:24];

  assign accept = (state == S_IDLE) && macro_states_valid
                  && is_cmd(macro_states);
  assign wip    = status_reg[0];

  // Read commands enter CMD straight from IDLE, before code_q is loaded.
  assign code_c = (state == S_IDLE) ? macro_states : code_q;
  assign addr_c = (state == S_IDLE) ? addr_reg[23:0] : addr_q;

  flash_poll_timer #(
    .POLL_GAP(POLL_GAP),
    .POLL_MAX(POLL_MAX)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .gap_load    (gap_load),
    .poll_clr    (poll_clr),
    .poll_inc    (poll_inc),
    .gap_expire  (gap_expire),
    .poll_timeout(poll_timeout)
  );

`ifdef FLASH_SEQ_TIMEOUT_EN
  logic err_q;
  assign timed_out = poll_timeout;
  assign flash_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = poll_timeout;
  assign timed_out = 1'b0;
  assign flash_err = 1'b0;
`endif

  always_comb begin
    cmd_req = '0;
    unique case (1'b1)
      code_c == M_ERS4K: begin
        cmd_req.cmd      = OP_SE;
        cmd_req.addr     = addr_c;
        cmd_req.has_addr = 1'b1;
      end
      code_c == M_RDID: begin
        cmd_req.cmd = OP_RDID;
        cmd_req.len = 9'd3;
      end
      code_c == M_WRPG: begin
        cmd_req.cmd      = OP_PP;
        cmd_req.addr     = addr_c;
        cmd_req.has_addr = 1'b1;
        cmd_req.len      = 9'(PG_BYTES);
      end
      code_c == M_RDPG: begin
        cmd_req.cmd      = OP_READ;
        cmd_req.addr     = addr_c;
        cmd_req.has_addr = 1'b1;
        cmd_req.len      = 9'(PG_BYTES);
      end
      code_c == M_RDSR: begin
        cmd_req.cmd = OP_RDSR;
        cmd_req.len = 9'd1;
      end
      code_c == M_RDFR: begin
        cmd_req.cmd = OP_RDFR;
        cmd_req.len = 9'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n  = state;
    gap_load = 1'b0;
    poll_clr = 1'b0;
    poll_inc = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          poll_clr = 1'b1;
          state_n  = needs_wren(macro_states) ? S_WREN : S_CMD;
        end
      end
      S_WREN:    state_n = S_WREN_WT;
      S_WREN_WT: if (qspi_done) state_n = S_CMD;
      S_CMD:     state_n = S_CMD_WT;
      S_CMD_WT: begin
        if (qspi_done) begin
          if (needs_wren(code_q)) begin
            gap_load = 1'b1;
            state_n  = S_GAP;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_GAP:     if (gap_expire) state_n = S_RDSR;
      S_RDSR:    state_n = S_RDSR_WT;
      S_RDSR_WT: if (qspi_done) state_n = S_CHECK;
      S_CHECK: begin
        if (!wip || timed_out) begin
          state_n = S_DONE;
        end else begin
          poll_inc = 1'b1;
          gap_load = 1'b1;
          state_n  = S_GAP;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Request fields are loaded on entry to an issue state and then
  // held untouched through the matching wait state.
  always_comb begin
    req_n = req_q;
    unique case (state_n)
      S_IDLE: req_n = '0;
      S_WREN: req_n = '{cmd: OP_WREN, addr: '0,
                        has_addr: 1'b0, len: 9'd0};
      S_CMD:  if (state != S_CMD) req_n = cmd_req;
      S_RDSR: req_n = '{cmd: OP_RDSR, addr: '0,
                        has_addr: 1'b0, len: 9'd1};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_q      <= '0;
      code_q     <= '0;
      addr_q     <= '0;
      status_reg <= '0;
      id_reg     <= '0;
    end else begin
      state <= state_n;
      req_q <= req_n;
      if (accept) begin
        code_q <= macro_states;
        addr_q <= addr_reg[23:0];
      end
      if (qspi_rd_valid) begin
        if (state == S_CMD_WT && code_q == M_RDID)
          id_reg <= {id_reg[15:0], qspi_rd_data};
        if ((state == S_CMD_WT &&
             (code_q == M_RDSR || code_q == M_RDFR)) ||
            state == S_RDSR_WT)
          status_reg <= qspi_rd_data;
      end
    end
  end

`ifdef FLASH_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (accept)
      err_q <= 1'b0;
    else if (state == S_CHECK && wip && timed_out)
      err_q <= 1'b1;
  end
`endif

  assign qspi_start = (state == S_WREN) || (state == S_CMD)
                      || (state == S_RDSR);
  assign qspi_cmd      = req_q.cmd;
  assign qspi_addr     = req_q.addr;
  assign qspi_has_addr = req_q.has_addr;
  assign qspi_len      = req_q.len;

  assign flash_busy              = (state != S_IDLE);
  assign flash_macro_states_done = (state == S_DONE);

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Directed bench for flash_op_sequencer with a small QSPI engine model.
// Build with FLASH_SEQ_TIMEOUT_EN to include the poll-timeout steps.
module tb_flash_op_sequencer;

  logic        clk;
  logic        rst;
  logic [3:0]  macro_states;
  logic        macro_states_valid;
  logic [31:0] addr_reg;
  logic        flash_macro_states_done;
  logic        flash_busy;
  logic        flash_err;
  logic        qspi_start;
  logic [7:0]  qspi_cmd;
  logic [23:0] qspi_addr;
  logic        qspi_has_addr;
  logic [8:0]  qspi_len;
  logic        qspi_done;
  logic [7:0]  qspi_rd_data;
  logic        qspi_rd_valid;
  logic [7:0]  status_reg;
  logic [23:0] id_reg;

  flash_op_sequencer #(
    .POLL_GAP(64),
    .POLL_MAX(4),
    .PG_BYTES(256)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .macro_states           (macro_states),
    .macro_states_valid     (macro_states_valid),
    .addr_reg               (addr_reg),
    .flash_macro_states_done(flash_macro_states_done),
    .flash_busy             (flash_busy),
    .flash_err              (flash_err),
    .qspi_start             (qspi_start),
    .qspi_cmd               (qspi_cmd),
    .qspi_addr              (qspi_addr),
    .qspi_has_addr          (qspi_has_addr),
    .qspi_len               (qspi_len),
    .qspi_done              (qspi_done),
    .qspi_rd_data           (qspi_rd_data),
    .qspi_rd_valid          (qspi_rd_valid),
    .status_reg             (status_reg),
    .id_reg                 (id_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]  st_cmd  [64];
  logic [23:0] st_addr [64];
  logic [8:0]  st_len  [64];
  logic        st_has  [64];
  int          st_ncyc [64];
  int          n_st = 0;
  int          n_unstable = 0;
  logic        chk_stable = 1'b1;

  logic [7:0] id_b [3];
  logic [7:0] sr_q [$];
  logic [7:0] sr_stuck = 8'h00;

  int   ncyc = 0;
  int   last_qdone = 0;
  int   n_done = 0;
  int   done_at = 0;
  logic err_at_done = 1'b0;
  logic busy_at_done = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (qspi_done) last_qdone = ncyc;
    if (flash_macro_states_done) begin
      n_done++;
      done_at      = ncyc;
      err_at_done  = flash_err;
      busy_at_done = flash_busy;
    end
  end

  task automatic stab(input int k);
    if (chk_stable && (qspi_start || qspi_cmd !== st_cmd[k] ||
        qspi_addr !== st_addr[k] || qspi_len !== st_len[k]))
      n_unstable++;
  endtask

  function automatic logic [7:0] next_sr();
    if (sr_q.size() > 0) return sr_q.pop_front();
    return sr_stuck;
  endfunction

  // Engine: two idle cycles, then read bytes, then a qspi_done pulse.
  initial begin
    int k;
    int nb;
    qspi_done     = 1'b0;
    qspi_rd_valid = 1'b0;
    qspi_rd_data  = 8'h00;
    @(posedge clk); #1;
    forever begin
      if (qspi_start) begin
        k = n_st;
        st_cmd[k]  = qspi_cmd;
        st_addr[k] = qspi_addr;
        st_len[k]  = qspi_len;
        st_has[k]  = qspi_has_addr;
        st_ncyc[k] = ncyc;
        n_st++;
        repeat (2) begin
          @(posedge clk); #1;
          stab(k);
        end
        nb = (st_cmd[k] == 8'h9F) ? 3 :
             (st_cmd[k] == 8'h05 || st_cmd[k] == 8'h70) ? 1 : 0;
        for (int i = 0; i < nb; i++) begin
          qspi_rd_valid = 1'b1;
          qspi_rd_data  = (nb == 3) ? id_b[i] : next_sr();
          @(posedge clk); #1;
          stab(k);
        end
        qspi_rd_valid = 1'b0;
        qspi_done     = 1'b1;
        @(posedge clk); #1;
        qspi_done = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] code, input logic [31:0] a);
    macro_states       = code;
    addr_reg           = a;
    macro_states_valid = 1'b1;
    @(posedge clk); #1;
    macro_states_valid = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [3:0] code,
                       input logic [31:0] a);
    pulse(code, a);
    chk({tag, "_start"}, 32'(qspi_start), 32'd1);
    chk({tag, "_busy"}, 32'(flash_busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int base,
                           input int budget);
    int t;
    t = 0;
    while (n_done == base && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk({tag, "_done_seen"}, 32'(n_done != base), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int b_st;
    int b_dn;
    int t;
    rst                = 1'b1;
    macro_states       = 4'h0;
    macro_states_valid = 1'b0;
    addr_reg           = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(flash_busy), 32'd0);
    chk("rst_done", 32'(flash_macro_states_done), 32'd0);
    chk("rst_err", 32'(flash_err), 32'd0);
    chk("rst_start", 32'(qspi_start), 32'd0);
    chk("rst_cmd", 32'(qspi_cmd), 32'd0);
    chk("rst_addr", 32'(qspi_addr), 32'd0);
    chk("rst_len", 32'(qspi_len), 32'd0);
    chk("rst_has", 32'(qspi_has_addr), 32'd0);
    chk("rst_sr", 32'(status_reg), 32'd0);
    chk("rst_id", 32'(id_reg), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // RdID
    id_b = '{8'h20, 8'hBA, 8'h18};
    b_st = n_st;
    b_dn = n_done;
    issue("rdid", 4'hB, 32'h0);
    chk("rdid_cmd", 32'(qspi_cmd), 32'h9F);
    chk("rdid_len", 32'(qspi_len), 32'd3);
    chk("rdid_has", 32'(qspi_has_addr), 32'd0);
    wait_done("rdid", b_dn, 200);
    chk("rdid_id", 32'(id_reg), 32'h0020BA18);
    chk("rdid_lat", 32'(done_at - last_qdone), 32'd1);
    chk("rdid_nst", 32'(n_st - b_st), 32'd1);
    chk("rdid_ndone", 32'(n_done - b_dn), 32'd1);
    chk("rdid_busy_at_done", 32'(busy_at_done), 32'd1);
    chk("rdid_busy_after", 32'(flash_busy), 32'd0);

    // Erase 4kB, two busy polls then clear
    sr_q = '{8'h03, 8'h03, 8'h00};
    b_st = n_st;
    b_dn = n_done;
    issue("ers", 4'hA, 32'h00001000);
    chk("ers_wren_cmd", 32'(qspi_cmd), 32'h06);
    wait_done("ers", b_dn, 3000);
    chk("ers_nst", 32'(n_st - b_st), 32'd5);
    chk("ers_c0", 32'(st_cmd[b_st]), 32'h06);
    chk("ers_c1", 32'(st_cmd[b_st+1]), 32'h20);
    chk("ers_a1", 32'(st_addr[b_st+1]), 32'h001000);
    chk("ers_h1", 32'(st_has[b_st+1]), 32'd1);
    chk("ers_l1", 32'(st_len[b_st+1]), 32'd0);
    for (int i = 2; i < 5; i++) begin
      chk("ers_rdsr", 32'(st_cmd[b_st+i]), 32'h05);
      chk("ers_rdsr_len", 32'(st_len[b_st+i]), 32'd1);
      chk("ers_gap", 32'(st_ncyc[b_st+i] - st_ncyc[b_st+i-1] >= 64),
          32'd1);
    end
    chk("ers_lat", 32'(done_at - last_qdone), 32'd2);
    chk("ers_ndone", 32'(n_done - b_dn), 32'd1);
    chk("ers_err", 32'(err_at_done), 32'd0);
    chk("ers_sr", 32'(status_reg), 32'h00);

    // Page program, first poll clear
    sr_q = '{8'h00};
    b_st = n_st;
    b_dn = n_done;
    issue("wrpg", 4'hC, 32'h0000FF00);
    wait_done("wrpg", b_dn, 2000);
    chk("wrpg_nst", 32'(n_st - b_st), 32'd3);
    chk("wrpg_c0", 32'(st_cmd[b_st]), 32'h06);
    chk("wrpg_c1", 32'(st_cmd[b_st+1]), 32'h02);
    chk("wrpg_l1", 32'(st_len[b_st+1]), 32'd256);
    chk("wrpg_a1", 32'(st_addr[b_st+1]), 32'h00FF00);
    chk("wrpg_c2", 32'(st_cmd[b_st+2]), 32'h05);
    chk("wrpg_ndone", 32'(n_done - b_dn), 32'd1);

    // Invalid code in IDLE, then valid while busy
    b_st = n_st;
    b_dn = n_done;
    pulse(4'h5, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("ign5_busy", 32'(flash_busy), 32'd0);
    chk("ign5_nst", 32'(n_st - b_st), 32'd0);
    sr_q = '{8'h01, 8'h00};
    issue("ersb", 4'hA, 32'h00002000);
    repeat (10) @(posedge clk);
    #1;
    pulse(4'hE, 32'h0);
    wait_done("ersb", b_dn, 3000);
    repeat (10) @(posedge clk);
    #1;
    chk("ersb_nst", 32'(n_st - b_st), 32'd4);
    chk("ersb_c3", 32'(st_cmd[b_st+3]), 32'h05);
    chk("ersb_ndone", 32'(n_done - b_dn), 32'd1);
    chk("ersb_busy", 32'(flash_busy), 32'd0);

`ifdef FLASH_SEQ_TIMEOUT_EN
    // Stuck WIP: bounded at four polls
    sr_stuck = 8'h01;
    b_st = n_st;
    b_dn = n_done;
    issue("tmo", 4'hA, 32'h00003000);
    wait_done("tmo", b_dn, 3000);
    chk("tmo_nst", 32'(n_st - b_st), 32'd6);
    chk("tmo_err_at_done", 32'(err_at_done), 32'd1);
    chk("tmo_err_hold", 32'(flash_err), 32'd1);
    sr_stuck = 8'h00;
    b_dn = n_done;
    issue("tmo_clr", 4'hE, 32'h0);
    chk("tmo_err_clr", 32'(flash_err), 32'd0);
    wait_done("tmo_clr", b_dn, 200);
    chk("tmo_clr_err", 32'(err_at_done), 32'd0);
`endif

    // Reset while the program command is in flight
    chk_stable = 1'b0;
    b_dn = n_done;
    issue("rstm", 4'hC, 32'h00000100);
    t = 0;
    while (!(qspi_start && qspi_cmd == 8'h02) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("rstm_pp_seen", 32'(t < 200), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstm_busy", 32'(flash_busy), 32'd0);
    chk("rstm_start", 32'(qspi_start), 32'd0);
    chk("rstm_cmd", 32'(qspi_cmd), 32'd0);
    chk("rstm_done", 32'(flash_macro_states_done), 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rstm_no_done", 32'(n_done - b_dn), 32'd0);
    chk_stable = 1'b1;

    // RdSR after the abort
    sr_q = '{8'h42};
    b_st = n_st;
    b_dn = n_done;
    issue("rdsr", 4'hE, 32'h0);
    chk("rdsr_cmd", 32'(qspi_cmd), 32'h05);
    wait_done("rdsr", b_dn, 200);
    chk("rdsr_sr", 32'(status_reg), 32'h42);
    chk("rdsr_nst", 32'(n_st - b_st), 32'd1);
    chk("rdsr_lat", 32'(done_at - last_qdone), 32'd1);

    chk("field_stability", 32'(n_unstable), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/flash_op_sequencer.md
Name: flash_op_sequencer

Overview:
- Converts one flash macro command (erase 4kB, page program, read ID/page/status/flag) from the top-level macro state machine into an ordered series of byte-level QSPI transactions.
- Issues WREN before erase/program, then polls the status register until WIP clears.
- Returns a single-cycle flash_macro_states_done.
- Sits between the macro state machine and the QSPI transaction engine; it is the only master of that engine.

Parameters:
- POLL_GAP, 64, idle clk cycles between successive RDSR polls.
- POLL_MAX, 200000, max RDSR polls before timeout (used only with FLASH_SEQ_TIMEOUT_EN).
- PG_BYTES, 256, data bytes per page program/read.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- macro_states  in  4  command code: A=ERS4kB, B=RdID, C=WrPg, D=RdPg, E=RdSR, F=RdFR.
- macro_states_valid  in  1  1-cycle command strobe.
- addr_reg  in  32  flash byte address; bits [23:0] are used.
- flash_macro_states_done  out  1  1-cycle completion pulse.
- flash_busy  out  1  high from command accept until the done pulse, inclusive.
- flash_err  out  1  timeout flag, valid with done.
- qspi_start  out  1  1-cycle transaction start.
- qspi_cmd  out  8  opcode.
- qspi_addr  out  24  transaction address.
- qspi_has_addr  out  1  send 3 address bytes.
- qspi_len  out  9  data byte count (0..256).
- qspi_done  in  1  1-cycle transaction complete.
- qspi_rd_data  in  8  read byte.
- qspi_rd_valid  in  1  read byte strobe.
- status_reg  out  8  last SR/FR byte read.
- id_reg  out  24  last JEDEC ID read (first byte in [23:16]).

Behaviour:
- Reset: all outputs 0; state IDLE; poll and gap counters 0. Reset mid-operation aborts immediately with no done pulse. qspi_* outputs drop to 0 the next cycle.
- IDLE: on macro_states_valid, latch code and addr_reg[23:0]; flash_busy=1 next cycle.
  - Codes 0..9 are ignored: no busy, no done.
  - valid while busy is ignored (not queued).
- Opcode map: A→0x20 addr len0; B→0x9F len3; C→0x02 addr len PG_BYTES; D→0x03 addr len PG_BYTES; E→0x05 len1; F→0x70 len1.
- States: IDLE → (A,C) WREN → WREN_WT → CMD → CMD_WT → GAP → RDSR → RDSR_WT → CHECK → DONE → IDLE.
  - Read codes (B,D,E,F): IDLE → CMD → CMD_WT → DONE.
- WREN/CMD/RDSR states assert qspi_start for exactly one cycle with the cmd/addr/len fields set. Those fields are held stable until the matching qspi_done.
- *_WT states wait for qspi_done.
- GAP counts POLL_GAP cycles.
- CHECK: status_reg[0]==0 → DONE; otherwise increment poll count → GAP.
- Latency:
  - Accept at cycle n → first qspi_start at n+1.
  - Done is asserted the cycle after the final qspi_done (reads) or the cycle after CHECK sees WIP=0.
- Read capture:
  - RdID: each qspi_rd_valid shifts id_reg left 8 and inserts the byte.
  - SR/FR and poll reads: load status_reg.
  - RdPg data is not captured; the engine routes it.
- DONE: flash_macro_states_done=1 for one cycle; flash_busy falls the same edge as done falls.
- qspi_done outside a *_WT state is ignored.

Optional Feature:
- FLASH_SEQ_TIMEOUT_EN defined: poll count reaching POLL_MAX in CHECK with WIP=1 goes to DONE with flash_err=1. flash_err clears on the next accepted command.
- Macro not defined: polling is unbounded, flash_err is tied 0, and POLL_MAX is unused.

Decomposition:
- Shared package (flash_pkg): macro code constants A..F, opcode constants (0x06, 0x20, 0x02, 0x03, 0x05, 0x70, 0x9F), state encoding typedef, PG_BYTES default.
- One natural sub-module: flash_poll_timer, the gap/poll counter with load/expire/timeout outputs.

Test Plan:
- RdID, engine returns 0x20, 0xBA, 0x18 → one start with cmd 0x9F, len 3, no addr; id_reg=0x20BA18; done 1 cycle after qspi_done.
- ERS4kB at addr 0x001000, SR model returns 0x03, 0x03, 0x00 → starts in order 0x06, 0x20 (addr 0x001000), 0x05 ×3; gaps ≥64 cycles; one done; flash_err=0.
- WrPg at 0x0000FF00, SR clears on first poll → 0x06, then 0x02 with len 256 and addr 0x00FF00, then one 0x05; done.
- With FLASH_SEQ_TIMEOUT_EN and POLL_MAX=4, SR stuck 0x01 → exactly 4 RDSR; done with flash_err=1. The next RdSR clears flash_err.
- Second valid during a busy erase, and code 0x5 in IDLE → both ignored; qspi_start count unchanged; one done total.
- rst asserted in CMD_WT of a program → next cycle IDLE, busy=0, no done. A subsequent RdSR completes normally.
